// File: rtl/tpctrl_pkg.sv
// rtl/tpctrl_pkg.sv - shared constants and types for the transpose-memory ping-pong controller
// Contents: N (rows/columns per block), CNT_W (bank shadow counter width),
//           COL_W (output column counter width), DEFAULT_BW (default element width),
//           bank_sel_t (which bank is currently filling).
package tpctrl_pkg;

    localparam int N          = 16;
    localparam int CNT_W      = 5;
    localparam int COL_W      = 4;
    localparam int DEFAULT_BW = 12;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_t;

endpackage

// File: rtl/tpctrl_bank_track.sv
// rtl/tpctrl_bank_track.sv - shadow copy of one transpose bank's fill/drain counter
// Optional feature macro: TPCTRL_CHECK_EN (adds the exp_en output).
// Ports:
//   i_clk, i_Reset  clock, synchronous active-high reset
//   we              write enable issued to the bank this cycle
//   cnt             shadow counter: 0..15 filling, 16..31 draining
//   full            pulse in the cycle the 16th row is written (cnt 15 -> 16)
//   draining        bank is emitting columns (cnt bit 4)
//   exp_en          (TPCTRL_CHECK_EN only) expected bank output-enable, one
//                   cycle behind the counter as the bank registers its enable
module tpctrl_bank_track
    import tpctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_Reset,
    input  logic             we,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             draining
`ifdef TPCTRL_CHECK_EN
    ,
    output logic             exp_en
`endif
);

    // Advances on every write while filling, then free-runs through the
    // 16 drain states and wraps back to 0 (EMPTY).
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            cnt <= '0;
        end else if (we | cnt[CNT_W-1]) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign full     = we & (cnt == CNT_W'(N - 1));
    assign draining = cnt[CNT_W-1];

`ifdef TPCTRL_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            exp_en <= 1'b0;
        end else begin
            exp_en <= cnt[CNT_W-1];
        end
    end
`endif

endmodule

// File: rtl/tpmem_pingpong_ctrl.sv
// rtl/tpmem_pingpong_ctrl.sv - ping-pong scheduler for two 16x16 transpose memory banks
// Optional feature macro: TPCTRL_CHECK_EN (sticky bank-enable consistency checker on o_err).
// Ports:
//   i_clk, i_Reset        clock, synchronous active-high reset
//   i_valid, i_data       input row (element 0 in MSBs), accepted when i_valid & o_ready
//   o_ready               controller can accept a row (combinational)
//   o_en_a, o_en_b        write enables to bank A / B (combinational)
//   o_wdata               row broadcast to both banks
//   i_data_a, i_data_b    column outputs of bank A / B
//   i_en_a, i_en_b        output-enables of bank A / B
//   o_data, o_valid       merged registered column stream
//   o_sop, o_eop          first / last column of a block
//   o_err                 sticky consistency error (0 unless TPCTRL_CHECK_EN)
module tpmem_pingpong_ctrl
    import tpctrl_pkg::*;
#(
    parameter int BW = DEFAULT_BW
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic            i_valid,
    input  logic [N*BW-1:0] i_data,
    output logic            o_ready,
    output logic            o_en_a,
    output logic            o_en_b,
    output logic [N*BW-1:0] o_wdata,
    input  logic [N*BW-1:0] i_data_a,
    input  logic [N*BW-1:0] i_data_b,
    input  logic            i_en_a,
    input  logic            i_en_b,
    output logic [N*BW-1:0] o_data,
    output logic            o_valid,
    output logic            o_sop,
    output logic            o_eop,
    output logic            o_err
);

    bank_sel_t        wsel;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             full_a, full_b;
    logic             drain_a, drain_b;
    logic             fill_draining;
    logic             full_sel;
    logic             accept;
    logic             any_en;
    logic [COL_W-1:0] col;

    // Counts are kept as ports for debug visibility; control uses the
    // decoded full/draining flags.
    logic             unused_cnt;
    assign unused_cnt = ^{cnt_a, cnt_b};

`ifdef TPCTRL_CHECK_EN
    logic exp_a, exp_b;
    logic err;
`endif

    tpctrl_bank_track u_track_a (
        .i_clk    (i_clk),
        .i_Reset  (i_Reset),
        .we       (o_en_a),
        .cnt      (cnt_a),
        .full     (full_a),
        .draining (drain_a)
`ifdef TPCTRL_CHECK_EN
        ,
        .exp_en   (exp_a)
`endif
    );

    tpctrl_bank_track u_track_b (
        .i_clk    (i_clk),
        .i_Reset  (i_Reset),
        .we       (o_en_b),
        .cnt      (cnt_b),
        .full     (full_b),
        .draining (drain_b)
`ifdef TPCTRL_CHECK_EN
        ,
        .exp_en   (exp_b)
`endif
    );

    // Input side. With continuous input the new fill bank cannot complete
    // before the other bank wraps, so o_ready only guards the reset cycle in
    // practice; it is kept so a bank is never written while draining.
    assign fill_draining = (wsel == BANK_A) ? drain_a : drain_b;
    assign o_ready       = ~i_Reset & ~fill_draining;
    assign accept        = i_valid & o_ready;
    assign o_en_a        = accept & (wsel == BANK_A);
    assign o_en_b        = accept & (wsel == BANK_B);
    assign o_wdata       = i_data;
    assign full_sel      = (wsel == BANK_A) ? full_a : full_b;

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            wsel <= BANK_A;
        end else if (full_sel) begin
            wsel <= (wsel == BANK_A) ? BANK_B : BANK_A;
        end
    end

    // Output side: fully registered so bank timing never reaches o_*.
    // Drains never overlap, so A-first priority only matters on error.
    assign any_en = i_en_a | i_en_b;

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            col     <= '0;
        end else begin
            o_valid <= any_en;
            o_data  <= i_en_a ? i_data_a : (i_en_b ? i_data_b : '0);
            o_sop   <= any_en & (col == '0);
            o_eop   <= any_en & (col == COL_W'(N - 1));
            if (any_en) begin
                col <= col + COL_W'(1);
            end
        end
    end

`ifdef TPCTRL_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            err <= 1'b0;
        end else if ((i_en_a & i_en_b) | (i_en_a != exp_a) | (i_en_b != exp_b)) begin
            err <= 1'b1;
        end
    end
    assign o_err = err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_tpmem_pingpong_ctrl.sv
// tb/tb_tpmem_pingpong_ctrl.sv - scoreboard bench for tpmem_pingpong_ctrl with behavioural bank models
module tb_tpmem_pingpong_ctrl;
    import tpctrl_pkg::*;

    localparam int BW = DEFAULT_BW;
    localparam int W  = N * BW;
`ifdef TPCTRL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
    } col_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         force_b = 1'b0;
    logic         o_ready, o_en_a, o_en_b, o_valid, o_sop, o_eop, o_err;
    logic [W-1:0] o_wdata, o_data;

    logic [BW-1:0] mem [2][16][16];
    logic [4:0]    bc [2];
    logic [1:0]    bank_en_q;
    logic [W-1:0]  bank_dq [2];

    col_t         sb[$];
    int           sop_exp[$];
    int           runs[$];
    int           cyc = 0;
    int           run = 0;
    int           vectors = 0;
    int           fails = 0;
    int           n_en_a = 0, n_en_b = 0, n_notready = 0, n_sop = 0;
    logic [BW-1:0] blk [16][16];
    int           nrow = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tpmem_pingpong_ctrl dut (
        .i_clk    (clk),
        .i_Reset  (rst),
        .i_valid  (valid),
        .i_data   (din),
        .o_ready  (o_ready),
        .o_en_a   (o_en_a),
        .o_en_b   (o_en_b),
        .o_wdata  (o_wdata),
        .i_data_a (bank_dq[0]),
        .i_data_b (bank_dq[1]),
        .i_en_a   (bank_en_q[0]),
        .i_en_b   (bank_en_q[1] | force_b),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_sop    (o_sop),
        .o_eop    (o_eop),
        .o_err    (o_err)
    );

    // Bank models: write rows while filling, then emit 16 columns with a
    // registered enable, reset together with the controller.
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                bc[b]        <= '0;
                bank_en_q[b] <= 1'b0;
                bank_dq[b]   <= '0;
            end else begin
                if (b == 0 ? o_en_a : o_en_b)
                    for (int c = 0; c < 16; c++)
                        mem[b][bc[b][3:0]][c] <= o_wdata[(15-c)*BW +: BW];
                bank_en_q[b] <= bc[b][4];
                for (int r = 0; r < 16; r++)
                    bank_dq[b][(15-r)*BW +: BW] <= bc[b][4] ? mem[b][r][bc[b][3:0]] : '0;
                if ((b == 0 ? o_en_a : o_en_b) | bc[b][4])
                    bc[b] <= bc[b] + 5'd1;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        fails++;
        $display("FAIL %s: got output with no expectation queued (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a column.
    always @(negedge clk) begin
        col_t e;
        if (rst) begin
            run = 0;
        end else begin
            if (o_valid) begin
                run++;
                if (sb.size() == 0) unexpected("col_extra");
                else begin
                    e = sb.pop_front();
                    check("col_data", o_data, e.data);
                    check("col_sop", W'(o_sop), W'(e.sop));
                    check("col_eop", W'(o_eop), W'(e.eop));
                end
            end else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (o_sop) begin
                n_sop++;
                if (sop_exp.size() == 0) unexpected("sop_extra");
                else check("sop_cycle", W'(cyc), W'(sop_exp.pop_front()));
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            n_en_a += int'(o_en_a);
            n_en_b += int'(o_en_b);
            n_notready += int'(!o_ready);
        end
    end

    function automatic logic [W-1:0] const_row(input int v);
        logic [W-1:0] r;
        for (int c = 0; c < 16; c++) r[(15-c)*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] ramp_row(input int seed, input int r);
        logic [W-1:0] x;
        for (int c = 0; c < 16; c++) x[(15-c)*BW +: BW] = BW'(seed + 16*r + c);
        return x;
    endfunction

    // Drive one cycle; on acceptance record the row and, at the 16th,
    // queue the transposed block and its expected sop cycle.
    task automatic send_row(input logic v, input logic [W-1:0] row);
        int k;
        col_t e;
        @(negedge clk);
        valid = v;
        din   = row;
        #1;
        k = cyc + 1;
        if (v & o_ready) begin
            for (int c = 0; c < 16; c++) blk[nrow][c] = row[(15-c)*BW +: BW];
            nrow++;
            if (nrow == 16) begin
                for (int c = 0; c < 16; c++) begin
                    for (int r = 0; r < 16; r++) e.data[(15-r)*BW +: BW] = blk[r][c];
                    e.sop = (c == 0);
                    e.eop = (c == 15);
                    sb.push_back(e);
                end
                sop_exp.push_back(k + 2);
                nrow = 0;
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_ready", W'(o_ready), '0);
            check("rst_en", W'({o_en_a, o_en_b}), '0);
            check("rst_valid", W'(o_valid), '0);
            check("rst_data", o_data, '0);
            check("rst_sopeop", W'({o_sop, o_eop}), '0);
            check("rst_err", W'(o_err), '0);
        end
        sb.delete();
        sop_exp.delete();
        runs.delete();
        nrow = 0;
        rst = 1'b0;
        #1;
        check("ready_after_rst", W'(o_ready), W'(1));
        n_en_a = 0; n_en_b = 0; n_notready = 0; n_sop = 0;
    endtask

    task automatic wait_idle(input int exp_run);
        int t = 0;
        @(negedge clk);
        valid = 1'b0;
        while ((sb.size() != 0 || o_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("drain_done", W'(sb.size() == 0 && sop_exp.size() == 0), W'(1));
        check("run_count", W'(runs.size()), W'(1));
        if (runs.size() > 0) check("run_len", W'(runs[0]), W'(exp_run));
        runs.delete();
    endtask

    initial begin
        int t;
        // Reset held for two cycles
        do_reset(2);

        // Single block, row r = all (r+1); columns are 1..16
        for (int r = 0; r < 16; r++) send_row(1'b1, const_row(r + 1));
        wait_idle(16);
        check("single_en_a", W'(n_en_a), W'(16));
        check("single_en_b", W'(n_en_b), '0);
        check("single_sops", W'(n_sop), W'(1));

        // Back-to-back 48 rows: A, B, A with one continuous output run
        do_reset(1);
        for (int i = 0; i < 48; i++) send_row(1'b1, ramp_row(256 * (i / 16) + 7, i % 16));
        wait_idle(48);
        check("b2b_en_a", W'(n_en_a), W'(32));
        check("b2b_en_b", W'(n_en_b), W'(16));
        check("b2b_notready", W'(n_notready), '0);
        check("b2b_sops", W'(n_sop), W'(3));

        // Gapped 1-0-1-0 input over 32 cycles
        do_reset(1);
        for (int i = 0; i < 32; i++) send_row((i % 2) == 0, ramp_row(12'h500, i / 2));
        wait_idle(16);
        check("gap_en_a", W'(n_en_a), W'(16));
        check("gap_en_b", W'(n_en_b), '0);

        // Reset mid-fill: 7 stale rows discarded
        do_reset(1);
        for (int i = 0; i < 7; i++) send_row(1'b1, const_row(12'h7AA));
        do_reset(1);
        for (int i = 0; i < 16; i++) send_row(1'b1, ramp_row(12'h100, i));
        wait_idle(16);
        check("midrst_en_a", W'(n_en_a), W'(16));
        check("midrst_sops", W'(n_sop), W'(1));

        // Consistency checker: spurious bank B enable while A drains
        do_reset(1);
        for (int i = 0; i < 16; i++) send_row(1'b1, ramp_row(12'h300, i));
        @(negedge clk);
        valid = 1'b0;
        t = 0;
        while (!bank_en_q[0] && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("a_draining", W'(bank_en_q[0]), W'(1));
        force_b = 1'b1;
        @(negedge clk);
        force_b = 1'b0;
        @(negedge clk);
        check("err_set", W'(o_err), W'(EXP_ERR));
        wait_idle(16);
        check("err_sticky", W'(o_err), W'(EXP_ERR));
        do_reset(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
